// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns a decoded field set into a 32-bit word behind a
// single output register, tags it with its imem byte address and flags bad requests.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_class,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        accept, xfer;
    logic [31:0] enc;
    logic        class_ok, range_ok;
    logic        is_shift;
    logic signed [31:0] imm_s;

    assign imm_s    = $signed(in_imm);
    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = valid_q && out_ready;

    // Field packing and immediate range check per instruction class.
    always_comb begin
        enc      = '0;
        class_ok = 1'b1;
        range_ok = 1'b1;
        case (in_class)
            3'd0: begin
                enc      = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
                range_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            3'd1: begin
                enc      = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
                range_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            3'd2: begin
                enc = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            end
            3'd3: begin
                enc      = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                            in_imm[4:1], in_imm[11], 7'b1100011};
                range_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
            end
            3'd4: begin
                if (is_shift) begin
                    enc      = {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3,
                                in_rd, 7'b0010011};
                    range_ok = (imm_s >= 32'sd0) && (imm_s <= 32'sd31);
                end else begin
                    enc      = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                    range_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
                end
            end
            3'd5: begin
                enc      = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
                range_ok = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];
            end
            default: class_ok = 1'b0;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (xfer) begin
            valid_d = 1'b0;
            addr_d  = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
        end
        if (accept) begin
            if (class_ok && range_ok) begin
                valid_d = 1'b1;
                instr_d = enc;
            end else if (!err_q) begin
                // Only the first fault is recorded; later ones are swallowed silently.
                err_d      = 1'b1;
                err_code_d = class_ok ? 2'd2 : 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4 so address wrap is reached quickly).
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_funct7b5, out_valid, out_ready, err;
    logic [2:0]  in_class, in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr, out_addr;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err), .err_code(err_code)
    );

    int          checks = 0, errors = 0;
    int          xfers = 0, last_wait = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_addr = 32'h0;
    bit          burst_done;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference encoder: returns {legal, word}.
    function automatic logic [32:0] model(input logic [2:0] c, input logic [4:0] rd, rs1, rs2,
                                          input logic [2:0] f3, input logic f7,
                                          input logic signed [31:0] imm);
        logic [31:0] w;
        logic        ok;
        w  = '0;
        ok = 1'b1;
        case (c)
            3'd0: begin w = {imm[11:0], rs1, 3'b010, rd, 7'h03}; ok = imm >= -2048 && imm <= 2047; end
            3'd1: begin w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23}; ok = imm >= -2048 && imm <= 2047; end
            3'd2: w = {1'b0, f7, 5'b0, rs2, rs1, f3, rd, 7'h33};
            3'd3: begin
                w  = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
                ok = imm >= -4096 && imm <= 4094 && (imm % 2 == 0);
            end
            3'd4: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    w  = {1'b0, f7, 5'b0, imm[4:0], rs1, f3, rd, 7'h13};
                    ok = imm >= 0 && imm <= 31;
                end else begin
                    w  = {imm[11:0], rs1, f3, rd, 7'h13};
                    ok = imm >= -2048 && imm <= 2047;
                end
            end
            3'd5: begin
                w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
                ok = imm >= -1048576 && imm <= 1048574 && (imm % 2 == 0);
            end
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] c, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                        input logic f7, input logic [31:0] imm, input logic legal,
                        input logic [31:0] exp_instr);
        bit done = 0;
        in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7b5 = f7; in_imm = imm; in_valid = 1'b1;
        last_wait = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            last_wait++;
            if (in_ready) begin
                done = 1;
                if (legal) sb_q.push_back(exp_instr);
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic sendm(input logic [2:0] c, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                         input logic f7, input logic [31:0] imm);
        logic [32:0] m;
        m = model(c, rd, rs1, rs2, f3, f7, imm);
        send(c, rd, rs1, rs2, f3, f7, imm, m[32], m[31:0]);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        sb_q.delete();
        exp_addr = 32'h0;
        #1 reset = 1'b0;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr", out_addr, 32'd0);
        chk("rst_err", {29'd0, err, err_code}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (sb_q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", sb_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", out_instr, 32'hXXXX_XXXX);
            end else begin
                chk("sb_instr", out_instr, sb_q.pop_front());
                chk("sb_addr", out_addr, exp_addr);
            end
            exp_addr = (exp_addr == 32'hC) ? 32'h0 : exp_addr + 32'd4;
            xfers++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7b5 = 1'b0; in_imm = '0;
        @(posedge clk); #1;
        do_reset();

        // add x3,x1,x2
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, 32'h002081B3);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_instr", out_instr, 32'h002081B3);
        chk("add_addr", out_addr, 32'h0);
        drain();

        // back-to-back addi / lw / sw
        do_reset();
        send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1, 32'h00500093);
        send(3'd0, 5'd2, 5'd1, 5'd0, 3'd2, 1'b0, 32'd8, 1'b1, 32'h0080A103);
        chk("b2b_lw_wait", last_wait, 32'd1);
        send(3'd1, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd12, 1'b1, 32'h0020A623);
        chk("b2b_sw_wait", last_wait, 32'd1);
        drain();

        // beq then jal under backpressure
        do_reset();
        out_ready = 1'b0;
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd4, 1'b1, 32'hFE208EE3);
        fork
            send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b1, 32'h008000EF);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_hold", out_instr, 32'hFE208EE3);
                    chk("stall_addr", out_addr, 32'h0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // sticky error: illegal class first, then range error, then a good word
        do_reset();
        x0 = xfers;
        send(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("err_cls", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd1});
        send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096, 1'b0, 32'd0);
        chk("err_sticky", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd1});
        send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1, 32'h00500093);
        drain();
        chk("err_one_word", xfers - x0, 32'd1);

        // range boundaries, first error is a range error
        do_reset();
        send(3'd0, 5'd1, 5'd2, 5'd0, 3'd2, 1'b0, 32'd2048, 1'b0, 32'd0);
        chk("err_range", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd2});
        send(3'd4, 5'd5, 5'd6, 5'd0, 3'd5, 1'b1, 32'd7, 1'b1, 32'h40735293);
        sendm(3'd0, 5'd1, 5'd2, 5'd0, 3'd2, 1'b0, 32'd2047);
        sendm(3'd0, 5'd1, 5'd2, 5'd0, 3'd2, 1'b0, -32'sd2048);
        sendm(3'd1, 5'd0, 5'd2, 5'd3, 3'd2, 1'b0, -32'sd2049);
        sendm(3'd3, 5'd0, 5'd4, 5'd5, 3'd0, 1'b0, 32'd4094);
        sendm(3'd3, 5'd0, 5'd4, 5'd5, 3'd0, 1'b0, -32'sd4096);
        sendm(3'd3, 5'd0, 5'd4, 5'd5, 3'd0, 1'b0, 32'd3);
        sendm(3'd3, 5'd0, 5'd4, 5'd5, 3'd0, 1'b0, 32'd4096);
        sendm(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1048574);
        sendm(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, -32'sd1048576);
        sendm(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1048576);
        sendm(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7);
        sendm(3'd4, 5'd7, 5'd8, 5'd0, 3'd1, 1'b0, 32'd31);
        sendm(3'd4, 5'd7, 5'd8, 5'd0, 3'd1, 1'b0, 32'd32);
        sendm(3'd4, 5'd7, 5'd8, 5'd0, 3'd5, 1'b0, -32'sd1);
        sendm(3'd6, 5'd7, 5'd8, 5'd0, 3'd0, 1'b0, 32'd0);
        drain();
        chk("err_range_sticky", {30'd0, err_code}, 32'd2);

        // random legal-ish burst with random backpressure
        do_reset();
        burst_done = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic signed [31:0] r;
                    r = 32'($signed($urandom_range(0, 128))) - 32'sd64;
                    sendm(3'($urandom_range(0, 5)), 5'($urandom), 5'($urandom), 5'($urandom),
                          3'($urandom), 1'($urandom), r * 2);
                end
                burst_done = 1;
            end
            while (!burst_done) begin
                @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
            end
        join
        out_ready = 1'b1;
        drain();

        // five transfers wrap the DEPTH=4 window, then reset with a word pending
        do_reset();
        x0 = xfers;
        for (int i = 0; i < 5; i++)
            sendm(3'd2, 5'(i + 1), 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
        drain();
        chk("wrap_xfers", xfers - x0, 32'd5);
        chk("wrap_addr", out_addr, 32'h4);
        out_ready = 1'b0;
        sendm(3'd2, 5'd9, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
        chk("pend_valid", {31'd0, out_valid}, 32'd1);
        do_reset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
